// File: rtl/window_allocator_if.sv
// Issue/positioner/output bundle between an issuer and one window_allocator slot.
// The master modport is the issuer/positioner/conv side, the slave modport is the allocator.
interface window_allocator_if #(
  parameter int DATA_WIDTH   = 8,
  parameter int MAX_HALFSIZE = 2
);
  localparam int MAX_WIN = (2*MAX_HALFSIZE+1)*(2*MAX_HALFSIZE+1);

  logic [7:0]                    image_dim;
  logic [8:0]                    image_depth;
  logic [1:0]                    filter_halfsize;
  logic [7:0]                    positioner_x;
  logic [7:0]                    positioner_y;
  logic                          positioner_select;
  logic [7:0]                    issue_x;
  logic [7:0]                    issue_y;
  logic [DATA_WIDTH-1:0]         issue_data;
  logic                          issue_en;
  logic                          issue_block;
  logic [MAX_WIN*DATA_WIDTH-1:0] out_window;
  logic                          out_valid;
  logic                          out_ready;
  logic [7:0]                    out_x;
  logic [7:0]                    out_y;
  logic [8:0]                    out_channel;
  logic                          busy;
  logic                          pos_err;

  modport master (
    output image_dim, image_depth, filter_halfsize,
    output positioner_x, positioner_y, positioner_select,
    output issue_x, issue_y, issue_data, issue_en, out_ready,
    input  issue_block, out_window, out_valid, out_x, out_y, out_channel, busy, pos_err
  );

  modport slave (
    input  image_dim, image_depth, filter_halfsize,
    input  positioner_x, positioner_y, positioner_select,
    input  issue_x, issue_y, issue_data, issue_en, out_ready,
    output issue_block, out_window, out_valid, out_x, out_y, out_channel, busy, pos_err
  );
endinterface

// File: rtl/window_allocator.sv
// One allocator slot: latches a window centre, captures issued pixels inside it and presents
// the full window once per depth channel. ALLOC_PAD_ZERO_EN enables zero padding of edge windows.
module window_allocator #(
  parameter int DATA_WIDTH   = 8,
  parameter int MAX_HALFSIZE = 2
) (
  input logic              clk,
  input logic              rst,
  window_allocator_if.slave bus
);
  localparam int WS      = 2*MAX_HALFSIZE+1;
  localparam int MAX_WIN = WS*WS;
  localparam int CW      = $clog2(MAX_WIN+1);
  localparam int KW      = $clog2(MAX_WIN);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_FULL    = 2'd2
  } state_t;

  state_t                        r_state;
  logic [7:0]                    r_x;
  logic [7:0]                    r_y;
  logic [1:0]                    r_h;
  logic [8:0]                    r_channel;
  logic [MAX_WIN-1:0]            r_valid;
  logic [MAX_WIN*DATA_WIDTH-1:0] r_window;
  logic [CW-1:0]                 r_count;
  logic [CW-1:0]                 r_win;
  logic                          r_issue_block;
  logic                          r_out_valid;
  logic                          r_busy;
  logic                          r_pos_err;

  logic [MAX_WIN-1:0] w_pad_sel;
  logic [MAX_WIN-1:0] w_pad_cur;
  logic [CW-1:0]      w_pad_sel_cnt;
  logic [CW-1:0]      w_pad_cur_cnt;
  logic               w_sel_ok;
  logic [9:0]         w_dx;
  logic [9:0]         w_dy;
  logic [9:0]         w_span;
  logic               w_hit;
  logic [KW-1:0]      w_k;
  logic               w_new;
  logic [CW-1:0]      w_count_next;

  function automatic logic [CW-1:0] win_cells(input logic [1:0] h);
    int side;
    side = 2*int'(h) + 1;
    return CW'(side*side);
  endfunction

  function automatic logic [CW-1:0] popcount(input logic [MAX_WIN-1:0] m);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < MAX_WIN; i++) begin
      c = c + {{(CW-1){1'b0}}, m[i]};
    end
    return c;
  endfunction

`ifdef ALLOC_PAD_ZERO_EN
  // Cells whose image coordinate falls outside 0..dim-1 are pre-marked valid with data 0
  function automatic logic [MAX_WIN-1:0] pad_mask(input logic [7:0] cx, input logic [7:0] cy,
                                                  input logic [1:0] h, input logic [7:0] dim);
    logic [MAX_WIN-1:0] m;
    m = '0;
    for (int dy = 0; dy < WS; dy++) begin
      for (int dx = 0; dx < WS; dx++) begin
        int side;
        int px;
        int py;
        int k;
        side = 2*int'(h) + 1;
        px   = int'(cx) - int'(h) + dx;
        py   = int'(cy) - int'(h) + dy;
        k    = dy*side + dx;
        if (dx < side && dy < side && k < MAX_WIN &&
            (px < 0 || py < 0 || px >= int'(dim) || py >= int'(dim))) begin
          m[k] = 1'b1;
        end
      end
    end
    return m;
  endfunction

  assign w_pad_sel = pad_mask(bus.positioner_x, bus.positioner_y, bus.filter_halfsize, bus.image_dim);
  assign w_pad_cur = pad_mask(r_x, r_y, r_h, bus.image_dim);
`else
  logic w_outside;
  assign w_outside = ({6'd0, bus.filter_halfsize} > bus.positioner_x) ||
                     ({6'd0, bus.filter_halfsize} > bus.positioner_y) ||
                     (({1'b0, bus.positioner_x} + {7'd0, bus.filter_halfsize}) >= {1'b0, bus.image_dim}) ||
                     (({1'b0, bus.positioner_y} + {7'd0, bus.filter_halfsize}) >= {1'b0, bus.image_dim});
  assign w_pad_sel = '0;
  assign w_pad_cur = '0;
`endif

  assign w_pad_sel_cnt = popcount(w_pad_sel);
  assign w_pad_cur_cnt = popcount(w_pad_cur);

  // Positioner assignment acceptance
  always_comb begin
    w_sel_ok = 1'b0;
    if (int'(bus.filter_halfsize) > MAX_HALFSIZE) begin
      w_sel_ok = 1'b0;
    end
`ifndef ALLOC_PAD_ZERO_EN
    else if (w_outside) begin
      w_sel_ok = 1'b0;
    end
`endif
    else begin
      w_sel_ok = 1'b1;
    end
  end

  // Offsets are 10-bit signed so a pixel left/above the window yields a negative value
  assign w_dx         = {2'b00, bus.issue_x} - {2'b00, r_x} + {8'd0, r_h};
  assign w_dy         = {2'b00, bus.issue_y} - {2'b00, r_y} + {8'd0, r_h};
  assign w_span       = {7'd0, r_h, 1'b0};
  assign w_hit        = bus.issue_en && (r_state == S_COLLECT) && !w_dx[9] && !w_dy[9] &&
                        (w_dx <= w_span) && (w_dy <= w_span);
  assign w_k          = KW'(w_dy) * KW'(w_span + 10'd1) + KW'(w_dx);
  assign w_new        = w_hit && !r_valid[w_k];
  assign w_count_next = r_count + {{(CW-1){1'b0}}, w_new};

  // Slot state machine, capture buffer and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_x           <= 8'd0;
      r_y           <= 8'd0;
      r_h           <= 2'd0;
      r_channel     <= 9'd0;
      r_valid       <= '0;
      r_window      <= '0;
      r_count       <= '0;
      r_win         <= '0;
      r_issue_block <= 1'b0;
      r_out_valid   <= 1'b0;
      r_busy        <= 1'b0;
      r_pos_err     <= 1'b0;
    end else begin
      r_pos_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.positioner_select) begin
            if (w_sel_ok) begin
              r_state   <= S_COLLECT;
              r_busy    <= 1'b1;
              r_x       <= bus.positioner_x;
              r_y       <= bus.positioner_y;
              r_h       <= bus.filter_halfsize;
              r_channel <= 9'd0;
              r_valid   <= w_pad_sel;
              r_count   <= w_pad_sel_cnt;
              r_win     <= win_cells(bus.filter_halfsize);
              r_window  <= '0;
            end else begin
              r_pos_err <= 1'b1;
            end
          end
        end
        S_COLLECT: begin
          r_pos_err <= bus.positioner_select;
          if (w_hit) begin
            r_window[w_k*DATA_WIDTH +: DATA_WIDTH] <= bus.issue_data;
            r_valid[w_k]                           <= 1'b1;
          end
          r_count <= w_count_next;
          if (w_count_next == r_win) begin
            r_state       <= S_FULL;
            r_issue_block <= 1'b1;
            r_out_valid   <= 1'b1;
          end
        end
        S_FULL: begin
          r_pos_err <= bus.positioner_select;
          if (bus.out_ready) begin
            r_issue_block <= 1'b0;
            r_out_valid   <= 1'b0;
            if (r_channel == bus.image_depth - 9'd1) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state   <= S_COLLECT;
              r_channel <= r_channel + 9'd1;
              r_valid   <= w_pad_cur;
              r_count   <= w_pad_cur_cnt;
              r_window  <= '0;
            end
          end
        end
        default: begin
          r_state       <= S_IDLE;
          r_busy        <= 1'b0;
          r_issue_block <= 1'b0;
          r_out_valid   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.issue_block = r_issue_block;
  assign bus.out_window  = r_window;
  assign bus.out_valid   = r_out_valid;
  assign bus.out_x       = r_x;
  assign bus.out_y       = r_y;
  assign bus.out_channel = r_channel;
  assign bus.busy        = r_busy;
  assign bus.pos_err     = r_pos_err;
endmodule

// File: tb/tb_window_allocator.sv
// Randomized bench for window_allocator against a coordinate-level window model.
module tb_window_allocator;
  localparam int DW = 8;
  localparam int MH = 2;
  localparam int MW = (2*MH+1)*(2*MH+1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  window_allocator_if #(.DATA_WIDTH(DW), .MAX_HALFSIZE(MH)) bus();
  window_allocator #(.DATA_WIDTH(DW), .MAX_HALFSIZE(MH)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  int         m_cx, m_cy, m_h, m_dim, m_need, m_got;
  logic [7:0] m_cell [MW];
  bit         m_have [MW];
  int         q_x[$], q_y[$], q_d[$];

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit in_image(int px, int py);
    return (px >= 0) && (px < m_dim) && (py >= 0) && (py < m_dim);
  endfunction

  // Fresh window for one channel: everything unknown except off-image cells when padding
  task automatic model_open();
    int side;
    side   = 2*m_h + 1;
    m_need = side*side;
    m_got  = 0;
    for (int k = 0; k < MW; k++) begin
      m_cell[k] = 8'd0;
      m_have[k] = 1'b0;
    end
`ifdef ALLOC_PAD_ZERO_EN
    for (int r = 0; r < side; r++) begin
      for (int c = 0; c < side; c++) begin
        if (!in_image(m_cx - m_h + c, m_cy - m_h + r)) begin
          m_have[r*side + c] = 1'b1;
          m_got++;
        end
      end
    end
`endif
  endtask

  task automatic model_beat(int ix, int iy, int d);
    int ax, ay, idx;
    ax = (ix > m_cx) ? ix - m_cx : m_cx - ix;
    ay = (iy > m_cy) ? iy - m_cy : m_cy - iy;
    if (ax <= m_h && ay <= m_h) begin
      idx         = (iy - m_cy + m_h)*(2*m_h + 1) + (ix - m_cx + m_h);
      m_cell[idx] = 8'(d);
      if (!m_have[idx]) begin
        m_have[idx] = 1'b1;
        m_got++;
      end
    end
  endtask

  function automatic logic [255:0] model_window();
    logic [255:0] w;
    w = '0;
    for (int k = 0; k < MW; k++) w[k*8 +: 8] = m_cell[k];
    return w;
  endfunction

  task automatic push_beat(int x, int y, int d);
    q_x.push_back(x);
    q_y.push_back(y);
    q_d.push_back(d);
  endtask

  task automatic gen_raster(int n);
    q_x.delete(); q_y.delete(); q_d.delete();
    for (int y = 0; y < n; y++)
      for (int x = 0; x < n; x++) push_beat(x, y, (x + 10*y) % 256);
  endtask

  // Shuffled in-image window cells with stray pixels and repeats mixed in
  task automatic gen_random();
    int cxs[$], cys[$];
    int j, t;
    q_x.delete(); q_y.delete(); q_d.delete();
    for (int dy = -m_h; dy <= m_h; dy++)
      for (int dx = -m_h; dx <= m_h; dx++)
        if (in_image(m_cx + dx, m_cy + dy)) begin
          cxs.push_back(m_cx + dx);
          cys.push_back(m_cy + dy);
        end
    for (int i = cxs.size() - 1; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = cxs[i]; cxs[i] = cxs[j]; cxs[j] = t;
      t = cys[i]; cys[i] = cys[j]; cys[j] = t;
    end
    for (int i = 0; i < cxs.size(); i++) begin
      if ($urandom_range(0, 3) == 0)
        push_beat($urandom_range(0, m_dim - 1), $urandom_range(0, m_dim - 1), $urandom_range(0, 255));
      push_beat(cxs[i], cys[i], $urandom_range(0, 255));
      if ($urandom_range(0, 4) == 0) push_beat(cxs[i], cys[i], $urandom_range(0, 255));
    end
  endtask

  task automatic select_win(input int cx, input int cy, input int h, input int dim, input int depth,
                            output bit ok);
    m_cx = cx; m_cy = cy; m_h = h; m_dim = dim;
`ifdef ALLOC_PAD_ZERO_EN
    ok = (h <= MH);
`else
    ok = (h <= MH) && (cx >= h) && (cy >= h) && (cx + h < dim) && (cy + h < dim);
`endif
    bus.image_dim         = 8'(dim);
    bus.image_depth       = 9'(depth);
    bus.filter_halfsize   = 2'(h);
    bus.positioner_x      = 8'(cx);
    bus.positioner_y      = 8'(cy);
    bus.positioner_select = 1'b1;
    tick();
    bus.positioner_select = 1'b0;
    check_eq("sel_pos_err", bus.pos_err, !ok);
    check_eq("sel_busy", bus.busy, ok);
    if (ok) check_eq("sel_out_x", bus.out_x, 8'(cx));
    tick();
    check_eq("pos_err_pulse", bus.pos_err, 1'b0);
  endtask

  task automatic feed(output int used);
    used = 0;
    while (used < q_x.size() && m_got < m_need) begin
      bus.issue_x    = 8'(q_x[used]);
      bus.issue_y    = 8'(q_y[used]);
      bus.issue_data = 8'(q_d[used]);
      bus.issue_en   = 1'b1;
      tick();
      model_beat(q_x[used], q_y[used], q_d[used]);
      check_eq("out_valid_collect", bus.out_valid, (m_got == m_need));
      used++;
    end
    bus.issue_en = 1'b0;
    check_eq("window_done", bus.out_valid, 1'b1);
  endtask

  task automatic handshake(input int gap, input bit last, input int ch);
    int centre;
    centre = m_h*(2*m_h + 1) + m_h;
    check_eq("issue_block_full", bus.issue_block, 1'b1);
    check_eq("out_window", bus.out_window, model_window());
    check_eq("out_x", bus.out_x, 8'(m_cx));
    check_eq("out_y", bus.out_y, 8'(m_cy));
    check_eq("out_channel", bus.out_channel, 9'(ch));
    for (int g = 0; g < gap; g++) begin
      bus.issue_x    = 8'(m_cx);
      bus.issue_y    = 8'(m_cy);
      bus.issue_data = ~m_cell[centre];
      bus.issue_en   = (g == 0);
      tick();
      check_eq("gap_out_valid", bus.out_valid, 1'b1);
      check_eq("gap_issue_block", bus.issue_block, 1'b1);
    end
    bus.issue_en = 1'b0;
    if (gap > 0) check_eq("window_held", bus.out_window, model_window());
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check_eq("post_hs_valid", bus.out_valid, 1'b0);
    check_eq("post_hs_block", bus.issue_block, 1'b0);
    check_eq("post_hs_busy", bus.busy, !last);
  endtask

  task automatic run_scenario(input int cx, input int cy, input int h, input int dim, input int depth,
                              input bit raster, input int gap);
    bit ok;
    int used;
    select_win(cx, cy, h, dim, depth, ok);
    if (ok) begin
      for (int ch = 0; ch < depth; ch++) begin
        model_open();
        if (raster) gen_raster(dim);
        else        gen_random();
        feed(used);
        handshake((gap < 0) ? $urandom_range(0, 4) : gap, ch == depth - 1, ch);
      end
    end
  endtask

  initial begin
    bit ok;
    int used;
    rst = 1'b1;
    bus.image_dim = 8'd0; bus.image_depth = 9'd1; bus.filter_halfsize = 2'd0;
    bus.positioner_x = 8'd0; bus.positioner_y = 8'd0; bus.positioner_select = 1'b0;
    bus.issue_x = 8'd0; bus.issue_y = 8'd0; bus.issue_data = 8'd0; bus.issue_en = 1'b0;
    bus.out_ready = 1'b0;
    tick(); tick();
    check_eq("rst_out_valid", bus.out_valid, 1'b0);
    check_eq("rst_busy", bus.busy, 1'b0);
    check_eq("rst_issue_block", bus.issue_block, 1'b0);
    check_eq("rst_window", bus.out_window, '0);
    rst = 1'b0;
    tick();

    // Raster fill around (5,5), explicit cell values
    select_win(5, 5, 1, 16, 1, ok);
    model_open();
    gen_raster(10);
    feed(used);
    check_eq("raster_cell0", bus.out_window[7:0], 8'd44);
    check_eq("raster_cell4", bus.out_window[39:32], 8'd55);
    check_eq("raster_cell8", bus.out_window[71:64], 8'd66);
    check_eq("raster_beats", used, 67);
    handshake(2, 1'b1, 0);

    // Three channels with long stalls
    run_scenario(3, 3, 1, 10, 3, 1'b1, 4);

    // Repeated coordinate overwrites without counting
    select_win(3, 3, 1, 10, 1, ok);
    model_open();
    q_x.delete(); q_y.delete(); q_d.delete();
    push_beat(3, 3, 7);
    push_beat(3, 3, 9);
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++)
        if (dx != 0 || dy != 0) push_beat(3 + dx, 3 + dy, 100 + 3*dy + dx);
    feed(used);
    check_eq("dup_beats", used, 10);
    check_eq("dup_centre", bus.out_window[39:32], 8'd9);
    handshake(1, 1'b1, 0);

    // Corner window: padded with the feature, rejected without it
    run_scenario(0, 0, 1, 8, 1, 1'b1, 1);
    check_eq("corner_idle", bus.busy, 1'b0);

    // Select while collecting, then oversize halfsize
    select_win(5, 5, 1, 12, 1, ok);
    model_open();
    bus.positioner_x = 8'd9; bus.positioner_y = 8'd9; bus.positioner_select = 1'b1;
    tick();
    bus.positioner_select = 1'b0;
    check_eq("busy_sel_err", bus.pos_err, 1'b1);
    check_eq("busy_sel_x", bus.out_x, 8'd5);
    check_eq("busy_sel_y", bus.out_y, 8'd5);
    tick();
    check_eq("busy_sel_pulse", bus.pos_err, 1'b0);
    gen_raster(12);
    feed(used);
    handshake(0, 1'b1, 0);
    select_win(5, 5, 3, 12, 1, ok);

    // Asynchronous reset while a full window is waiting
    select_win(4, 4, 1, 10, 1, ok);
    model_open();
    gen_raster(10);
    feed(used);
    rst = 1'b1;
    #2;
    check_eq("arst_block", bus.issue_block, 1'b0);
    check_eq("arst_valid", bus.out_valid, 1'b0);
    check_eq("arst_busy", bus.busy, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    run_scenario(4, 4, 1, 10, 1, 1'b0, 1);

    // Random geometry, depth and stalls
    for (int n = 0; n < 30; n++) begin
      int dim;
      dim = $urandom_range(5, 20);
      run_scenario($urandom_range(0, dim - 1), $urandom_range(0, dim - 1), $urandom_range(0, 3),
                   dim, $urandom_range(1, 2), 1'b0, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
